// File: rtl/sram_arbiter_ctrl.sv
// Round-robin two-port arbiter/sequencer driving a level-sensitive SRAM cell array.
// Latency: Req to Ack is 3 cycles, 4 cycles per transaction; backpressure: Req is held until Ack.
module sram_arbiter_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic             Req1,
    input  logic             We0,
    input  logic             We1,
    input  logic [AW-1:0]    Addr0,
    input  logic [AW-1:0]    Addr1,
    input  logic [WIDTH-1:0] WData0,
    input  logic [WIDTH-1:0] WData1,
    output logic             Ack0,
    output logic             Ack1,
    output logic [WIDTH-1:0] RData,
    output logic [AW-1:0]    Cell_Addr,
    output logic [WIDTH-1:0] Cell_Data,
    output logic             Cell_Write,
    output logic             Cell_Read,
    input  logic [WIDTH-1:0] Cell_Q,
    output logic             Busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0] state;
    logic       prio;
    logic       win;
    logic       we_l;
    logic       grant_sel;

    // Contention follows the pointer; a lone request always wins.
    always_comb begin
        grant_sel = 1'b0;
        if (Req0 && Req1) begin
            grant_sel = prio;
        end else begin
            grant_sel = Req1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            prio       <= 1'b0;
            win        <= 1'b0;
            we_l       <= 1'b0;
            Ack0       <= 1'b0;
            Ack1       <= 1'b0;
            RData      <= '0;
            Cell_Addr  <= '0;
            Cell_Data  <= '0;
            Cell_Write <= 1'b0;
            Cell_Read  <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Ack0       <= 1'b0;
            Ack1       <= 1'b0;
            Cell_Write <= 1'b0;
            Cell_Read  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req0 || Req1) begin
                        win       <= grant_sel;
                        we_l      <= grant_sel ? We1 : We0;
                        Cell_Addr <= grant_sel ? Addr1 : Addr0;
                        Cell_Data <= grant_sel ? WData1 : WData0;
                        Busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    // Address/data settled for a full cycle before the strobe opens.
                    Cell_Write <= we_l;
                    Cell_Read  <= !we_l;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    if (!we_l) begin
                        RData <= Cell_Q;
                    end
                    Ack0  <= !win;
                    Ack1  <= win;
                    state <= HOLD;
                end
                HOLD: begin
                    prio  <= !win;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
